// File: rtl/locked_adder_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : locked_adder_eval_pkg
//  Brief    : Shared widths, FSM state encoding and the reference key for the
//             locked-adder key-evaluation sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package locked_adder_eval_pkg;

  localparam int c_data_w = 32;
  localparam int c_res_w  = 33;

  // Known-good key of the locked netlist; used by the harness, not the sequencer.
  localparam logic [63:0] CORRECT_KEY = 64'h33DDEAB695CA827B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_APPLY   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/locked_adder_eval_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : locked_adder_eval_ctrl_if
//  Brief    : Operand-memory read port plus locked-adder drive/return bus.
//  Revision : 1.0 - initial release
// ============================================================================
interface locked_adder_eval_ctrl_if
  import locked_adder_eval_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int KEY_W  = 64
) ();

  logic                mem_rd_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [c_data_w-1:0] mem_data_i;
  logic [c_data_w-1:0] add1_o;
  logic [c_data_w-1:0] add2_o;
  logic [KEY_W-1:0]    key_o;
  logic [c_res_w-1:0]  result_i;

  modport master (
    output mem_rd_o, mem_addr_o, add1_o, add2_o, key_o,
    input  mem_data_i, result_i
  );

  modport slave (
    input  mem_rd_o, mem_addr_o, add1_o, add2_o, key_o,
    output mem_data_i, result_i
  );

endinterface
`default_nettype wire

// File: rtl/locked_adder_eval_popcnt33.sv
`default_nettype none
// ============================================================================
//  Module   : locked_adder_eval_popcnt33
//  Brief    : Combinational population count of a 33-bit word.
//  Revision : 1.0 - initial release
// ============================================================================
module locked_adder_eval_popcnt33 (
  input  logic [32:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = 6'd0;
    for (int i = 0; i < 33; i++) begin
      o_count = o_count + {5'd0, i_data[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/locked_adder_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : locked_adder_eval_ctrl
//  Brief    : Fetches operand pairs, applies them with one candidate key to the
//             locked adder and accumulates mismatch / flipped-bit statistics.
//             Optional macro FIRST_FAIL_CAPTURE_EN adds first-failure capture.
//  Revision : 1.0 - initial release
// ============================================================================
module locked_adder_eval_ctrl
  import locked_adder_eval_pkg::*;
#(
  parameter  int N_PAIRS = 10000,
  parameter  int ADDR_W  = 15,
  parameter  int KEY_W   = 64,
  localparam int VCW     = $clog2(N_PAIRS + 1),
  localparam int BCW     = $clog2(33 * N_PAIRS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [KEY_W-1:0]         key_i,
  locked_adder_eval_ctrl_if.master bus,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef FIRST_FAIL_CAPTURE_EN
  output logic                     first_fail_vld_o,
  output logic [ADDR_W-2:0]        first_fail_idx_o,
  output logic [c_res_w-1:0]       first_fail_res_o,
`endif
  output logic [VCW-1:0]           err_vec_cnt_o,
  output logic [BCW-1:0]           err_bit_cnt_o
);

  localparam int KW = ADDR_W - 1;

  localparam logic [2:0] c_st_idle    = ST_IDLE;
  localparam logic [2:0] c_st_fetch_a = ST_FETCH_A;
  localparam logic [2:0] c_st_fetch_b = ST_FETCH_B;
  localparam logic [2:0] c_st_apply   = ST_APPLY;
  localparam logic [2:0] c_st_check   = ST_CHECK;
  localparam logic [2:0] c_st_done    = ST_DONE;

  localparam logic [KW-1:0] c_last_k = KW'(N_PAIRS - 1);

  logic [2:0]          r_state;
  logic [KW-1:0]       r_k;
  logic [KEY_W-1:0]    r_key;
  logic [c_data_w-1:0] r_add1;
  logic [c_data_w-1:0] r_add2;
  logic [c_res_w-1:0]  r_golden;
  logic [ADDR_W-1:0]   r_addr_hold;
  logic                r_busy;
  logic                r_done;
  logic [VCW-1:0]      r_err_vec;
  logic [BCW-1:0]      r_err_bit;

  logic                w_fetch;
  logic [ADDR_W-1:0]   w_addr;
  logic [c_res_w-1:0]  w_diff;
  logic                w_mismatch;
  logic [5:0]          w_pop;
  logic                w_abort;
  logic                w_start;
  logic                w_check;

  assign w_fetch    = (r_state == c_st_fetch_a) || (r_state == c_st_fetch_b);
  assign w_diff     = bus.result_i ^ r_golden;
  assign w_mismatch = |w_diff;
  assign w_abort    = abort_i && (r_state != c_st_idle);
  assign w_start    = start_i && (r_state == c_st_idle);
  assign w_check    = (r_state == c_st_check) && !abort_i;

  // Address is driven straight from state so the read lands in the fetch cycle;
  // the hold register keeps it steady between fetches.
  always_comb begin
    w_addr = r_addr_hold;
    if (r_state == c_st_fetch_a) begin
      w_addr = {r_k, 1'b0};
    end else if (r_state == c_st_fetch_b) begin
      w_addr = {r_k, 1'b1};
    end
  end

  locked_adder_eval_popcnt33 u_popcnt (
    .i_data  (w_diff),
    .o_count (w_pop)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= c_st_idle;
      r_k         <= '0;
      r_key       <= '0;
      r_add1      <= '0;
      r_add2      <= '0;
      r_golden    <= '0;
      r_addr_hold <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_vec   <= '0;
      r_err_bit   <= '0;
    end else begin
      r_done      <= 1'b0;
      r_addr_hold <= w_addr;
      if (w_abort) begin
        r_state <= c_st_idle;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (start_i) begin
              r_key     <= key_i;
              r_k       <= '0;
              r_err_vec <= '0;
              r_err_bit <= '0;
              r_busy    <= 1'b1;
              r_state   <= c_st_fetch_a;
            end
          end
          c_st_fetch_a: r_state <= c_st_fetch_b;
          c_st_fetch_b: begin
            r_add1  <= bus.mem_data_i;
            r_state <= c_st_apply;
          end
          c_st_apply: begin
            r_add2   <= bus.mem_data_i;
            r_golden <= {1'b0, r_add1} + {1'b0, bus.mem_data_i};
            r_state  <= c_st_check;
          end
          c_st_check: begin
            if (w_mismatch) begin
              r_err_vec <= r_err_vec + VCW'(1);
            end
            r_err_bit <= r_err_bit + BCW'(w_pop);
            if (r_k == c_last_k) begin
              r_state <= c_st_done;
            end else begin
              r_k     <= r_k + KW'(1);
              r_state <= c_st_fetch_a;
            end
          end
          c_st_done: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= c_st_idle;
          end
          default: r_state <= c_st_idle;
        endcase
      end
    end
  end

`ifdef FIRST_FAIL_CAPTURE_EN
  logic                r_ff_vld;
  logic [KW-1:0]       r_ff_idx;
  logic [c_res_w-1:0]  r_ff_res;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ff_vld <= 1'b0;
      r_ff_idx <= '0;
      r_ff_res <= '0;
    end else if (w_start) begin
      r_ff_vld <= 1'b0;
      r_ff_idx <= '0;
      r_ff_res <= '0;
    end else if (w_check && w_mismatch && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_idx <= r_k;
      r_ff_res <= bus.result_i;
    end
  end

  assign first_fail_vld_o = r_ff_vld;
  assign first_fail_idx_o = r_ff_idx;
  assign first_fail_res_o = r_ff_res;
`endif

  assign bus.mem_rd_o   = w_fetch;
  assign bus.mem_addr_o = w_addr;
  assign bus.add1_o     = r_add1;
  assign bus.add2_o     = r_add2;
  assign bus.key_o      = r_key;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_vec_cnt_o  = r_err_vec;
  assign err_bit_cnt_o  = r_err_bit;

endmodule
`default_nettype wire

// File: tb/tb_locked_adder_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_locked_adder_eval_ctrl
//  Brief    : Directed self-checking bench, 3-pair operand set, fault-injecting
//             adder model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_locked_adder_eval_ctrl;

  localparam int NP  = 3;
  localparam int AW  = 3;
  localparam int KW  = 64;
  localparam int VCW = 2;
  localparam int BCW = 7;
  localparam logic [63:0] c_key_ok  = 64'h33DDEAB695CA827B;
  localparam logic [63:0] c_key_alt = 64'h33DDEAB695CA823B;

  logic clk = 1'b0;
  logic rst_i, start_i, abort_i;
  logic [KW-1:0]  key_i;
  logic busy_o, done_o;
  logic [VCW-1:0] err_vec_cnt_o;
  logic [BCW-1:0] err_bit_cnt_o;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic        first_fail_vld_o;
  logic [1:0]  first_fail_idx_o;
  logic [32:0] first_fail_res_o;
`endif

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  logic [32:0] fault_mask;
  logic [31:0] mem [0:7];

  always #5 clk = ~clk;

  locked_adder_eval_ctrl_if #(.ADDR_W(AW), .KEY_W(KW)) bus ();

  locked_adder_eval_ctrl #(.N_PAIRS(NP), .ADDR_W(AW), .KEY_W(KW)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .key_i            (key_i),
    .bus              (bus),
    .busy_o           (busy_o),
    .done_o           (done_o),
`ifdef FIRST_FAIL_CAPTURE_EN
    .first_fail_vld_o (first_fail_vld_o),
    .first_fail_idx_o (first_fail_idx_o),
    .first_fail_res_o (first_fail_res_o),
`endif
    .err_vec_cnt_o    (err_vec_cnt_o),
    .err_bit_cnt_o    (err_bit_cnt_o)
  );

  always @(posedge clk) begin
    if (bus.mem_rd_o) bus.mem_data_i <= mem[bus.mem_addr_o];
  end

  // Vectors are recognised by their operands: v0=(1,2) v1=(FFFFFFFF,1) v2=(0,0).
  always_comb begin
    fault_mask = 33'd0;
    case (fault_mode)
      1: if (bus.add1_o == 32'hFFFFFFFF) fault_mask = 33'h1_0000_0001;
      2: begin
        if (bus.add1_o == 32'hFFFFFFFF) fault_mask = 33'h1_0000_0001;
        else if (bus.add1_o == 32'd0 && bus.add2_o == 32'd0) fault_mask = 33'h0_0000_0020;
      end
      3: begin
        if (bus.add1_o == 32'd1) fault_mask = 33'h1_FFFF_FFFF;
        else if (bus.add1_o == 32'hFFFFFFFF) fault_mask = 33'h0_0000_0001;
      end
      default: fault_mask = 33'd0;
    endcase
  end

  assign bus.result_i = ({1'b0, bus.add1_o} + {1'b0, bus.add2_o}) ^ fault_mask;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after edge 0 (the edge that samples start_i).
  task automatic start_run(input logic [63:0] key, input int mode);
    @(negedge clk);
    start_i    = 1'b1;
    key_i      = key;
    fault_mode = mode;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; key_i = '0;
    step(3);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %0h exp 0", done_o); end
    checks++; if (bus.mem_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd got %0h exp 0", bus.mem_rd_o); end
    checks++; if (bus.key_o !== 64'd0) begin errors++; $display("FAIL reset_key got %0h exp 0", bus.key_o); end
    checks++; if ({err_vec_cnt_o, err_bit_cnt_o} !== 9'd0) begin errors++; $display("FAIL reset_cnt got %0h exp 0", {err_vec_cnt_o, err_bit_cnt_o}); end
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_ideal;
    start_run(c_key_ok, 0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ideal_busy_e0 got %0h exp 1", busy_o); end
    checks++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 3'd0) begin errors++; $display("FAIL ideal_rd_e0 got %0h/%0h exp 1/0", bus.mem_rd_o, bus.mem_addr_o); end
    step(1);
    checks++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 3'd1) begin errors++; $display("FAIL ideal_rd_e1 got %0h/%0h exp 1/1", bus.mem_rd_o, bus.mem_addr_o); end
    step(1);
    checks++; if (bus.mem_rd_o !== 1'b0 || bus.mem_addr_o !== 3'd1) begin errors++; $display("FAIL ideal_hold_e2 got %0h/%0h exp 0/1", bus.mem_rd_o, bus.mem_addr_o); end
    checks++; if (bus.add1_o !== 32'd1) begin errors++; $display("FAIL ideal_add1_e2 got %0h exp 1", bus.add1_o); end
    step(1);
    checks++; if (bus.add1_o !== 32'd1 || bus.add2_o !== 32'd2) begin errors++; $display("FAIL ideal_v0 got %0h,%0h exp 1,2", bus.add1_o, bus.add2_o); end
    step(1);
    checks++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 3'd2) begin errors++; $display("FAIL ideal_rd_e4 got %0h/%0h exp 1/2", bus.mem_rd_o, bus.mem_addr_o); end
    step(3);
    checks++; if (bus.add1_o !== 32'hFFFFFFFF || bus.add2_o !== 32'd1) begin errors++; $display("FAIL ideal_v1 got %0h,%0h exp ffffffff,1", bus.add1_o, bus.add2_o); end
    step(4);
    checks++; if (bus.add1_o !== 32'd0 || bus.add2_o !== 32'd0) begin errors++; $display("FAIL ideal_v2 got %0h,%0h exp 0,0", bus.add1_o, bus.add2_o); end
    step(1);
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL ideal_e12 got busy %0h done %0h exp 1 0", busy_o, done_o); end
    step(1);
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL ideal_e13 got busy %0h done %0h exp 0 1", busy_o, done_o); end
    checks++; if (err_vec_cnt_o !== 2'd0 || err_bit_cnt_o !== 7'd0) begin errors++; $display("FAIL ideal_cnt got %0d/%0d exp 0/0", err_vec_cnt_o, err_bit_cnt_o); end
    step(1);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ideal_e14_done got %0h exp 0", done_o); end
  endtask

  task automatic test_key_hold;
    start_run(c_key_ok, 1);
    step(2);
    key_i   = c_key_alt;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    checks++; if (bus.key_o !== c_key_ok) begin errors++; $display("FAIL key_mid got %0h exp %0h", bus.key_o, c_key_ok); end
    step(10);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL key_done_e13 got %0h exp 1", done_o); end
    checks++; if (bus.key_o !== c_key_ok) begin errors++; $display("FAIL key_end got %0h exp %0h", bus.key_o, c_key_ok); end
    checks++; if (err_vec_cnt_o !== 2'd1 || err_bit_cnt_o !== 7'd2) begin errors++; $display("FAIL fault1_cnt got %0d/%0d exp 1/2", err_vec_cnt_o, err_bit_cnt_o); end
    start_run(c_key_alt, 0);
    checks++; if (bus.key_o !== c_key_alt) begin errors++; $display("FAIL key_relatch got %0h exp %0h", bus.key_o, c_key_alt); end
    checks++; if (err_vec_cnt_o !== 2'd0 || err_bit_cnt_o !== 7'd0) begin errors++; $display("FAIL cnt_clear got %0d/%0d exp 0/0", err_vec_cnt_o, err_bit_cnt_o); end
    step(14);
  endtask

  task automatic test_multi_fault;
    start_run(c_key_ok, 2);
    step(13);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL multi_done got %0h exp 1", done_o); end
    checks++; if (err_vec_cnt_o !== 2'd2 || err_bit_cnt_o !== 7'd3) begin errors++; $display("FAIL multi_cnt got %0d/%0d exp 2/3", err_vec_cnt_o, err_bit_cnt_o); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (first_fail_vld_o !== 1'b1 || first_fail_idx_o !== 2'd1) begin errors++; $display("FAIL ff_idx got %0h/%0d exp 1/1", first_fail_vld_o, first_fail_idx_o); end
    checks++; if (first_fail_res_o !== 33'h0_0000_0001) begin errors++; $display("FAIL ff_res got %0h exp 1", first_fail_res_o); end
`endif
    step(1);
  endtask

  task automatic test_abort;
    int n_done;
    start_run(c_key_ok, 3);
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (first_fail_vld_o !== 1'b0) begin errors++; $display("FAIL ff_clear got %0h exp 0", first_fail_vld_o); end
`endif
    step(5);
    abort_i = 1'b1;
    step(1);
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || bus.mem_rd_o !== 1'b0) begin errors++; $display("FAIL abort_busy got %0h/%0h exp 0/0", busy_o, bus.mem_rd_o); end
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o !== 1'b0) n_done++;
      step(1);
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", n_done); end
    checks++; if (err_vec_cnt_o !== 2'd1 || err_bit_cnt_o !== 7'd33) begin errors++; $display("FAIL abort_cnt got %0d/%0d exp 1/33", err_vec_cnt_o, err_bit_cnt_o); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (first_fail_idx_o !== 2'd0 || first_fail_res_o !== 33'h1_FFFF_FFFC) begin errors++; $display("FAIL abort_ff got %0d/%0h exp 0/1fffffffc", first_fail_idx_o, first_fail_res_o); end
`endif
  endtask

  task automatic test_start_abort_idle;
    abort_i = 1'b1;
    start_run(c_key_ok, 0);
    abort_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || bus.mem_rd_o !== 1'b1) begin errors++; $display("FAIL start_abort got %0h/%0h exp 1/1", busy_o, bus.mem_rd_o); end
    step(13);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL start_abort_done got %0h exp 1", done_o); end
    step(1);
  endtask

  task automatic test_reset_mid;
    start_run(c_key_ok, 3);
    step(7);
    checks++; if (err_bit_cnt_o !== 7'd33 || bus.add1_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL pre_rst got %0d/%0h exp 33/ffffffff", err_bit_cnt_o, bus.add1_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || bus.mem_rd_o !== 1'b0) begin errors++; $display("FAIL rst_ctl got %0h%0h%0h exp 000", busy_o, done_o, bus.mem_rd_o); end
    checks++; if (bus.add1_o !== 32'd0 || bus.add2_o !== 32'd0 || bus.key_o !== 64'd0) begin errors++; $display("FAIL rst_data got %0h,%0h,%0h exp 0", bus.add1_o, bus.add2_o, bus.key_o); end
    checks++; if (err_vec_cnt_o !== 2'd0 || err_bit_cnt_o !== 7'd0 || bus.mem_addr_o !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d/%0d exp 0", err_vec_cnt_o, err_bit_cnt_o, bus.mem_addr_o); end
`ifdef FIRST_FAIL_CAPTURE_EN
    checks++; if (first_fail_vld_o !== 1'b0) begin errors++; $display("FAIL rst_ff got %0h exp 0", first_fail_vld_o); end
`endif
    @(negedge clk);
    rst_i = 1'b0;
    start_run(c_key_alt, 0);
    checks++; if (bus.mem_addr_o !== 3'd0) begin errors++; $display("FAIL rerun_addr got %0d exp 0", bus.mem_addr_o); end
    step(3);
    checks++; if (bus.add1_o !== 32'd1 || bus.add2_o !== 32'd2) begin errors++; $display("FAIL rerun_v0 got %0h,%0h exp 1,2", bus.add1_o, bus.add2_o); end
    step(10);
    checks++; if (done_o !== 1'b1 || err_vec_cnt_o !== 2'd0 || err_bit_cnt_o !== 7'd0) begin errors++; $display("FAIL rerun_end got %0h %0d/%0d exp 1 0/0", done_o, err_vec_cnt_o, err_bit_cnt_o); end
  endtask

  initial begin
    mem[0] = 32'd1;        mem[1] = 32'd2;
    mem[2] = 32'hFFFFFFFF; mem[3] = 32'd1;
    mem[4] = 32'd0;        mem[5] = 32'd0;
    mem[6] = 32'd0;        mem[7] = 32'd0;
    test_reset();
    test_ideal();
    test_key_hold();
    test_multi_fault();
    test_abort();
    test_start_abort_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/locked_adder_eval_ctrl.md
# locked_adder_eval_ctrl

Sequencer that drives a key-locked 32-bit adder netlist through a stored operand set under one candidate key. It fetches operand pairs from a word memory and applies them with the key. It checks each 33-bit result against an internally computed golden sum and accumulates output-corruption statistics: mismatching vectors and total flipped bits. It sits between the operand memory and the locked adder instance in the key-evaluation harness, one run per candidate key.

## Interface
- N_PAIRS, 10000: operand pairs per run; pair k is at words 2k (add1) and 2k+1 (add2).
- ADDR_W, 15: operand memory address width; requires 2*N_PAIRS <= 2**ADDR_W.
- KEY_W, 64: key width.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a run; accepted only in IDLE.
- abort_i  in  1  terminate the current run.
- key_i  in  KEY_W  candidate key, latched on accepted start.
- mem_rd_o  out  1  memory read strobe.
- mem_addr_o  out  ADDR_W  memory word address.
- mem_data_i  in  32  read data, valid exactly 1 cycle after mem_rd_o.
- add1_o, add2_o  out  32  operands to the locked adder.
- key_o  out  KEY_W  key to the locked adder.
- result_i  in  33  locked adder result (combinational netlist).
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at normal run completion.
- err_vec_cnt_o  out  VCW = $clog2(N_PAIRS+1)  vectors with result_i != golden.
- err_bit_cnt_o  out  BCW = $clog2(33*N_PAIRS+1)  sum of popcount(result_i ^ golden).

## Operation
- States: IDLE, FETCH_A, FETCH_B, APPLY, CHECK, DONE.
- IDLE: on start_i, latch key_i into key_o, clear k and both counters, then go to FETCH_A.
- FETCH_A: mem_rd_o=1, mem_addr_o=2k. Go to FETCH_B.
- FETCH_B: register mem_data_i into add1_o; mem_rd_o=1, mem_addr_o=2k+1. Go to APPLY.
- APPLY: register mem_data_i into add2_o. Register golden = {1'b0,add1}+{1'b0,add2} as a 33-bit sum. Go to CHECK.
- CHECK: sample result_i and compute d = result_i ^ golden.
  - If d != 0, increment err_vec_cnt_o.
  - Add popcount(d) to err_bit_cnt_o.
  - If k == N_PAIRS-1, go to DONE; else increment k and go to FETCH_A.
- DONE: done_o=1 for one cycle, then go to IDLE. Counters hold until the next accepted start.
- start_i outside IDLE is ignored.
- abort_i in any non-IDLE state goes to IDLE next cycle. No done_o pulse; counters keep partial values. abort_i has priority over all other transitions.
- Counters cannot overflow by construction; no saturation logic.
- mem_rd_o=0 outside FETCH_A/FETCH_B. mem_addr_o holds its last value.

## Timing
- Reset values: all outputs 0; state IDLE; k=0.
- 4 cycles per vector. With start_i sampled at edge 0, done_o is high in the cycle after edge 4*N_PAIRS+1.
- busy_o is high from the cycle after the accepted start through DONE inclusive.
- add1_o/add2_o/key_o are held stable for the full CHECK cycle. The locked adder path add→result_i must meet a single clock period.
- Simultaneous start_i and abort_i in IDLE: start is accepted and abort is ignored.
- Reset mid-run: all outputs return to reset values immediately.

## Configuration
- FIRST_FAIL_CAPTURE_EN, when defined, adds three outputs:
  - first_fail_vld_o (1 bit);
  - first_fail_idx_o (ADDR_W−1 bits);
  - first_fail_res_o (33 bits).
- These capture k and result_i at the first mismatching CHECK of a run. They are cleared on accepted start and reset, and held after capture.
- Without the macro these ports and registers are absent; behaviour is otherwise identical.

## Structure
- Package locked_adder_eval_pkg holds:
  - the state enum;
  - the data width 32 and result width 33;
  - the constant CORRECT_KEY = 64'h33DDEAB695CA827B, for harness use.
- Sub-module locked_adder_eval_popcnt33: combinational 33-bit popcount producing a 6-bit output.

## Test plan
- Ideal-adder model, N_PAIRS=3, memory {1,2,FFFFFFFF,1,0,0}:
  - applies sums 3, 1_00000000 and 0;
  - done_o at cycle 13 after start;
  - err_vec_cnt_o=0, err_bit_cnt_o=0.
- Model that inverts result bits 0 and 32 on vector 1 only: err_vec_cnt_o=1, err_bit_cnt_o=2.
- Change key_i to 64'h33DDEAB695CA823B mid-run: key_o stays 64'h33DDEAB695CA827B until the next start.
- abort_i at cycle 6 of a run:
  - busy_o falls the next cycle;
  - no done_o pulse;
  - counts reflect vector 0 only.
- rst_i asserted during CHECK: all outputs are 0 in the same cycle. A new start_i then runs cleanly from k=0.
- With FIRST_FAIL_CAPTURE_EN and model faults on vectors 1 and 2: first_fail_idx_o=1, and first_fail_res_o equals the corrupted vector-1 result.
